bfly20_stage: RTL and testbench

- First radix-2 butterfly of the module2 pipeline. Consumes the 12-bit CBFP-normalised stream from module1: 16 lanes per clock, 512-sample block over 32 cycles.
- Pairs sample n with n+256 using a 16-row feedback buffer. Emits all 256 sums (a+b), then all 256 differences (a−b), as 13-bit values at one 16-lane row per clock.
- The CBFP index is not consumed here; the separate index FIFO of module2 handles it.

---
 rtl/fft_pkg.sv | 49 ++++
 rtl/bfly20_row_buffer.sv | 29 ++
 rtl/bfly20_stage.sv | 126 ++++++++++++
 tb/tb_bfly20_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the module2 FFT datapath.
// The row helpers operate on all lanes of a row at once.
package fft_pkg;

  localparam int NUM_PARALLEL_PATHS = 16;
  localparam int IWIDTH             = 12;
  localparam int OWIDTH             = IWIDTH + 1;
  localparam int BLOCK_SIZE         = 512;
  localparam int HALF_ROWS          = BLOCK_SIZE / (2 * NUM_PARALLEL_PATHS);
  localparam int ROW_AW             = $clog2(HALF_ROWS);
  localparam int CNT_W              = ROW_AW + 1;

  typedef logic signed [IWIDTH-1:0] in12_t;
  typedef logic signed [OWIDTH-1:0] out13_t;

  typedef in12_t  [NUM_PARALLEL_PATHS-1:0] in_row_t;
  typedef out13_t [NUM_PARALLEL_PATHS-1:0] out_row_t;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_BFLY = 1'b1
  } wr_state_e;

  function automatic out_row_t row_sext(input in_row_t x);
    out_row_t r;
    for (int l = 0; l < NUM_PARALLEL_PATHS; l++) begin
      r[l] = {{(OWIDTH-IWIDTH){x[l][IWIDTH-1]}}, x[l]};
    end
    return r;
  endfunction

  // Operands originate from 12-bit samples, so 13 bits hold every result exactly.
  function automatic out_row_t row_add(input out_row_t a, input out_row_t b);
    out_row_t r;
    for (int l = 0; l < NUM_PARALLEL_PATHS; l++) begin
      r[l] = a[l] + b[l];
    end
    return r;
  endfunction

  function automatic out_row_t row_sub(input out_row_t a, input out_row_t b);
    out_row_t r;
    for (int l = 0; l < NUM_PARALLEL_PATHS; l++) begin
      r[l] = a[l] - b[l];
    end
    return r;
  endfunction

endpackage

// File: rtl/bfly20_row_buffer.sv
// Half-block feedback buffer: one asynchronous read port, one synchronous write port.
// A read and write to the same row in one cycle returns the old contents.
module bfly20_row_buffer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ROW_AW-1:0] wr_addr,
  input  out_row_t          wr_re,
  input  out_row_t          wr_im,
  input  logic [ROW_AW-1:0] rd_addr,
  output out_row_t          rd_re,
  output out_row_t          rd_im
);

  out_row_t mem_re [HALF_ROWS];
  out_row_t mem_im [HALF_ROWS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[wr_addr] <= wr_re;
      mem_im[wr_addr] <= wr_im;
    end
  end

  assign rd_re = mem_re[rd_addr];
  assign rd_im = mem_im[rd_addr];

endmodule

// File: rtl/bfly20_stage.sv
// First radix-2 butterfly of module2: pairs sample n with n+256 through a feedback
// buffer, emitting 16 sum rows followed by 16 difference rows per 512-sample block.
module bfly20_stage
  import fft_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     di_en,
  input  in_row_t  di_re,
  input  in_row_t  di_im,
  output logic     do_en,
  output logic     do_half,
  output out_row_t do_re,
  output out_row_t do_im
);

  logic [CNT_W-1:0]  wr_cnt;
  logic [ROW_AW-1:0] wr_row;
  logic [ROW_AW-1:0] drain_cnt;
  logic [ROW_AW-1:0] rd_addr;
  logic              drain_active;
  logic              last_row;
  logic              last_drain;
  logic              vld_sum_p0;
  logic              vld_dif_p0;
  wr_state_e         state;
  wr_state_e         state_nxt;

  out_row_t a_re_p0, a_im_p0;
  out_row_t b_re_p0, b_im_p0;
  out_row_t sum_re_p0, sum_im_p0;
  out_row_t dif_re_p0, dif_im_p0;
  out_row_t wr_re, wr_im;

  assign wr_row     = wr_cnt[ROW_AW-1:0];
  assign last_row   = di_en && (wr_cnt == {CNT_W{1'b1}});
  assign last_drain = drain_active && (drain_cnt == {ROW_AW{1'b1}});
  assign vld_sum_p0 = di_en && (state == ST_BFLY);
  assign vld_dif_p0 = drain_active;

  // A new block's sums need 16 accepted rows, so they never overlap a drain;
  // the single read port can therefore be handed to the drain while it runs.
  assign rd_addr = drain_active ? drain_cnt : wr_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (di_en && (wr_row == {ROW_AW{1'b1}})) state_nxt = ST_BFLY;
      ST_BFLY: if (last_row)                            state_nxt = ST_FILL;
      default:                                          state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt       <= '0;
      drain_cnt    <= '0;
      drain_active <= 1'b0;
    end else begin
      if (di_en) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
      if (last_row) begin
        drain_active <= 1'b1;
        drain_cnt    <= '0;
      end else if (drain_active) begin
        drain_cnt <= drain_cnt + ROW_AW'(1);
        if (last_drain) begin
          drain_active <= 1'b0;
        end
      end
    end
  end

  bfly20_row_buffer u_buf (
    .clk     (clk),
    .wr_en   (di_en),
    .wr_addr (wr_row),
    .wr_re   (wr_re),
    .wr_im   (wr_im),
    .rd_addr (rd_addr),
    .rd_re   (a_re_p0),
    .rd_im   (a_im_p0)
  );

  // Stage p0: butterfly on buffer row a and incoming row b
  always_comb begin
    b_re_p0   = row_sext(di_re);
    b_im_p0   = row_sext(di_im);
    sum_re_p0 = row_add(a_re_p0, b_re_p0);
    sum_im_p0 = row_add(a_im_p0, b_im_p0);
    dif_re_p0 = row_sub(a_re_p0, b_re_p0);
    dif_im_p0 = row_sub(a_im_p0, b_im_p0);
    wr_re     = (state == ST_BFLY) ? dif_re_p0 : b_re_p0;
    wr_im     = (state == ST_BFLY) ? dif_im_p0 : b_im_p0;
  end

  // Stage p1: registered outputs; data holds while no row is emitted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_en   <= 1'b0;
      do_half <= 1'b0;
      do_re   <= '0;
      do_im   <= '0;
    end else begin
      do_en   <= vld_sum_p0 || vld_dif_p0;
      do_half <= !vld_sum_p0 && vld_dif_p0;
      if (vld_sum_p0) begin
        do_re <= sum_re_p0;
        do_im <= sum_im_p0;
      end else if (vld_dif_p0) begin
        do_re <= a_re_p0;
        do_im <= a_im_p0;
      end
    end
  end

endmodule

// File: tb/tb_bfly20_stage.sv
// Bench for bfly20_stage: block-level reference model with cycle stamps, constant
// vector table for extremes, and hand-built sequences for gaps, overlap and reset.
module tb_bfly20_stage;
  import fft_pkg::*;

  localparam int NP = NUM_PARALLEL_PATHS;
  localparam int HR = HALF_ROWS;

  logic     clk;
  logic     rst;
  logic     di_en;
  in_row_t  di_re, di_im;
  logic     do_en, do_half;
  out_row_t do_re, do_im;

  bfly20_stage dut (
    .clk     (clk),
    .rst     (rst),
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .do_en   (do_en),
    .do_half (do_half),
    .do_re   (do_re),
    .do_im   (do_im)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int cyc;
    bit half;
    int re [NP];
    int im [NP];
  } exp_t;

  typedef struct {
    int a_re, a_im, b_re, b_im;
    int s_re, s_im, d_re, d_im;
  } tv_t;

  exp_t exp_q [$];
  tv_t  tv [4];

  int vectors     = 0;
  int miscompares = 0;
  int ecount      = 0;
  int mdl_cnt     = 0;
  int mdl_a_re [HR][NP];
  int mdl_a_im [HR][NP];
  int mdl_d_re [HR][NP];
  int mdl_d_im [HR][NP];
  int cap_re [2][2];
  int cap_im [2][2];
  out_row_t held_re, held_im;

  always @(posedge clk) ecount <= ecount + 1;

  function automatic int s12(input in12_t x);
    return int'(x);
  endfunction

  function automatic int s13(input out13_t x);
    return int'(x);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: rows 0..15 are held; row 16+r yields x[r]+x[16+r] at once, and row 31
  // releases the 16 differences on the following consecutive cycles.
  task automatic model_accept(input in_row_t re, input in_row_t im);
    exp_t e;
    int k;
    k = mdl_cnt;
    if (k < HR) begin
      for (int l = 0; l < NP; l++) begin
        mdl_a_re[k][l] = s12(re[l]);
        mdl_a_im[k][l] = s12(im[l]);
      end
    end else begin
      e.cyc  = ecount;
      e.half = 1'b0;
      for (int l = 0; l < NP; l++) begin
        e.re[l] = mdl_a_re[k-HR][l] + s12(re[l]);
        e.im[l] = mdl_a_im[k-HR][l] + s12(im[l]);
        mdl_d_re[k-HR][l] = mdl_a_re[k-HR][l] - s12(re[l]);
        mdl_d_im[k-HR][l] = mdl_a_im[k-HR][l] - s12(im[l]);
      end
      exp_q.push_back(e);
      if (k == 2*HR-1) begin
        for (int r = 0; r < HR; r++) begin
          e.cyc  = ecount + r + 1;
          e.half = 1'b1;
          e.re   = mdl_d_re[r];
          e.im   = mdl_d_im[r];
          exp_q.push_back(e);
        end
      end
    end
    mdl_cnt = (k + 1) % (2*HR);
  endtask

  task automatic drive_row(input in_row_t re, input in_row_t im);
    di_re = re;
    di_im = im;
    di_en = 1'b1;
    @(posedge clk);
    #1;
    model_accept(re, im);
    di_en = 1'b0;
  endtask

  task automatic idle(input int n);
    di_en = 1'b0;
    repeat (n) begin
      di_re = in_row_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      di_im = in_row_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    di_en = 1'b1;
    rst   = 1'b1;
    exp_q.delete();
    mdl_cnt = 0;
    repeat (3) begin
      di_re = in_row_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      di_im = in_row_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      @(posedge clk);
      #1;
    end
    di_en = 1'b0;
    rst   = 1'b0;
  endtask

  // mode 0: table constants, 1: random, 2: ramp 16r+k
  task automatic make_row(input int mode, input int ti, input int row,
                          output in_row_t re, output in_row_t im);
    for (int l = 0; l < NP; l++) begin
      case (mode)
        0: begin
          re[l] = in12_t'((row < HR) ? tv[ti].a_re : tv[ti].b_re);
          im[l] = in12_t'((row < HR) ? tv[ti].a_im : tv[ti].b_im);
        end
        1: begin
          re[l] = in12_t'($urandom);
          im[l] = in12_t'($urandom);
        end
        default: begin
          re[l] = in12_t'(16*row + l);
          im[l] = in12_t'(-(16*row + l));
        end
      endcase
    end
  endtask

  // gaps 1: fixed gaps after rows 7 and 20; gaps 2: random gaps
  task automatic feed_block(input int mode, input int ti, input int gaps, input int rows);
    in_row_t re, im;
    for (int row = 0; row < rows; row++) begin
      make_row(mode, ti, row, re, im);
      drive_row(re, im);
      if (gaps == 1 && row == 7)  idle(5);
      if (gaps == 1 && row == 20) idle(3);
      if (gaps == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
  endtask

  task automatic check_table(input int i, input string tag);
    check({tag, "_sum_re_l0"},  cap_re[0][0], tv[i].s_re);
    check({tag, "_sum_im_l15"}, cap_im[0][1], tv[i].s_im);
    check({tag, "_dif_re_l15"}, cap_re[1][1], tv[i].d_re);
    check({tag, "_dif_im_l0"},  cap_im[1][0], tv[i].d_im);
  endtask

  task automatic clear_cap();
    for (int h = 0; h < 2; h++) begin
      for (int s = 0; s < 2; s++) begin
        cap_re[h][s] = -99999;
        cap_im[h][s] = -99999;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   nbad, fl;
    if (rst) begin
      check("reset_do_en", int'(do_en), 0);
      check("reset_do_half", int'(do_half), 0);
      check("reset_data_nonzero", int'(do_re != '0 || do_im != '0), 0);
      held_re = '0;
      held_im = '0;
    end else if (do_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_row", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("row_cycle", ecount, e.cyc);
        check("row_half", int'(do_half), int'(e.half));
        nbad = 0;
        fl   = 0;
        for (int l = 0; l < NP; l++) begin
          if (s13(do_re[l]) != e.re[l] || s13(do_im[l]) != e.im[l]) begin
            if (nbad == 0) fl = l;
            nbad++;
          end
        end
        vectors++;
        if (nbad != 0) begin
          miscompares++;
          $display("FAIL row_data half=%0d lane %0d: got re=%0d im=%0d, expected re=%0d im=%0d (%0d lanes bad)",
                   e.half, fl, s13(do_re[fl]), s13(do_im[fl]), e.re[fl], e.im[fl], nbad);
        end
        cap_re[do_half][0] = s13(do_re[0]);
        cap_im[do_half][0] = s13(do_im[0]);
        cap_re[do_half][1] = s13(do_re[NP-1]);
        cap_im[do_half][1] = s13(do_im[NP-1]);
      end
      held_re = do_re;
      held_im = do_im;
    end else begin
      check("idle_do_half", int'(do_half), 0);
      check("idle_hold", int'(do_re == held_re && do_im == held_im), 1);
      if (exp_q.size() > 0 && exp_q[0].cyc <= ecount) begin
        check("missing_row", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst   = 1'b1;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    tv[0] = '{a_re:  100, a_im:   -50, b_re:    30, b_im:    20,
              s_re:  130, s_im:   -30, d_re:    70, d_im:   -70};
    tv[1] = '{a_re: 2047, a_im:  2047, b_re:  2047, b_im:  2047,
              s_re: 4094, s_im:  4094, d_re:     0, d_im:     0};
    tv[2] = '{a_re:-2048, a_im: -2048, b_re:  2047, b_im: -2048,
              s_re:   -1, s_im: -4096, d_re: -4095, d_im:     0};
    tv[3] = '{a_re: 2047, a_im: -2048, b_re: -2048, b_im:  2047,
              s_re:   -1, s_im:    -1, d_re:  4095, d_im: -4095};
    clear_cap();

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    idle(3);

    // 15 rows must produce nothing; then discard the partial block
    feed_block(1, 0, 0, 15);
    idle(6);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      clear_cap();
      feed_block(0, i, 0, 32);
      idle(20);
      check_table(i, "tv");
    end

    clear_cap();
    feed_block(0, 0, 1, 32);
    idle(20);
    check_table(0, "gaps");

    feed_block(1, 0, 0, 32);
    feed_block(2, 0, 0, 32);
    feed_block(1, 0, 0, 32);
    idle(20);

    feed_block(1, 0, 0, 23);
    do_reset();
    feed_block(1, 0, 0, 32);
    idle(20);

    repeat (3) feed_block(1, 0, 2, 32);
    idle(20);

    check("pending_rows_at_end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
